// File: rtl/seq_div32_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div32_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } div_state_e;

endpackage

// File: rtl/seq_div32_sub_stage.sv
// Ripple-carry subtractor: a + ~b + 1, borrow is the inverted carry out.
module seq_div32_sub_stage #(
   parameter int unsigned WIDTH = 33
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_b_n;

   assign w_carry[0] = 1'b1;
   assign w_b_n      = ~i_b;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign o_diff[i]    = i_a[i] ^ w_b_n[i] ^ w_carry[i];
      assign w_carry[i+1] = (i_a[i] & w_b_n[i]) | (w_carry[i] & (i_a[i] ^ w_b_n[i]));
   end

   assign o_borrow = ~w_carry[WIDTH];

endmodule

// File: rtl/seq_div32.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_div32
   import seq_div32_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   div_state_e       r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a, r_b, r_q, r_quot, r_rmd;
   logic [WIDTH:0]   r_rem, w_rshift, w_diff, w_rem_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             r_dz_pend, r_dz, r_done;
   logic             w_done_d, w_borrow, w_accept, w_last;
   logic             w_unused_rem_msb;

   // Restored remainder is always below the divisor, so its MSB never feeds the next shift.
   assign w_unused_rem_msb = r_rem[WIDTH];

   assign w_rshift  = {r_rem[WIDTH-1:0], r_a[WIDTH-1]};
   assign w_rem_nxt = w_borrow ? w_rshift : w_diff;
   assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_accept  = i_start && (r_state != StRun);

   seq_div32_sub_stage #(
      .WIDTH (WIDTH + 1)
   ) u_sub_stage (
      .i_a      (w_rshift),
      .i_b      ({1'b0, r_b}),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   always_comb begin
      w_state_d = r_state;
      w_done_d  = 1'b0;
      unique case (r_state)
         StIdle, StDone: begin
            if (i_start) w_state_d = StRun;
         end
         StRun: begin
            if (r_dz_pend || w_last) begin
               w_state_d = StDone;
               w_done_d  = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_done  <= w_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_q       <= '0;
         r_rem     <= '0;
         r_dz_pend <= 1'b0;
         r_dz      <= 1'b0;
         r_quot    <= '0;
         r_rmd     <= '0;
      end else if (w_accept) begin
         r_cnt     <= '0;
         r_a       <= i_dividend;
         r_b       <= i_divisor;
         r_q       <= '0;
         r_rem     <= '0;
         r_dz_pend <= (i_divisor == '0);
         r_dz      <= 1'b0;
      end else if (r_state == StRun) begin
         if (r_dz_pend) begin
            // r_a has not been shifted yet, so it still holds the dividend.
            r_quot <= '1;
            r_rmd  <= r_a;
            r_dz   <= 1'b1;
         end else begin
            r_a   <= {r_a[WIDTH-2:0], 1'b0};
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_quot <= w_q_nxt;
               r_rmd  <= w_rem_nxt[WIDTH-1:0];
            end
         end
      end
   end

   assign o_busy        = (r_state == StRun);
   assign o_done        = r_done;
   assign o_quotient    = r_quot;
   assign o_remainder   = r_rmd;
   assign o_div_by_zero = r_dz;

endmodule
